// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, FD pipeline latch and fetch control FSM.
// Define FETCH_SKID_EN to add a one-entry skid buffer (HOLD state) that keeps a word returned during a stall.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] fd_instr,
  output logic [31:0] fd_pc_plus_4,
  output logic        fd_valid,
  output logic        fetch_halted
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] HALT_WORD  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] WORD_BYTES = XLEN'(4);

`ifdef FETCH_SKID_EN
  typedef enum logic [1:0] {FETCH = 2'd0, HALTED = 2'd1, HOLD = 2'd2} state_e;
`else
  typedef enum logic [1:0] {FETCH = 2'd0, HALTED = 2'd1} state_e;
`endif

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] fd_instr_q, fd_instr_d;
  logic [XLEN-1:0] fd_pc4_q, fd_pc4_d;
  logic            fd_valid_q, fd_valid_d;
  logic            ren_q, ren_d;
  logic            halted_q, halted_d;
  logic [XLEN-1:0] pc_plus_4;
`ifdef FETCH_SKID_EN
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc4_q, skid_pc4_d;
`endif

  assign pc_plus_4 = pc_q + WORD_BYTES;

  // Next-state logic; priority is redirect > flush > stall > ihit.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fd_instr_d = fd_instr_q;
    fd_pc4_d   = fd_pc4_q;
    fd_valid_d = fd_valid_q;
`ifdef FETCH_SKID_EN
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
`endif
    if (redirect) begin
      pc_d       = redirect_addr;
      fd_valid_d = 1'b0;
      fd_instr_d = '0;
      state_d    = FETCH;
`ifdef FETCH_SKID_EN
      skid_instr_d = '0;
      skid_pc4_d   = '0;
`endif
    end else if (flush) begin
      fd_valid_d = 1'b0;
      fd_instr_d = '0;
    end else if (stall) begin
`ifdef FETCH_SKID_EN
      if (state_q == FETCH && ihit) begin
        skid_instr_d = imemload;
        skid_pc4_d   = pc_plus_4;
        state_d      = HOLD;
      end
`endif
    end else begin
      case (state_q)
        FETCH: begin
          if (ihit) begin
            fd_instr_d = imemload;
            fd_pc4_d   = pc_plus_4;
            fd_valid_d = 1'b1;
            if (imemload == HALT_WORD) state_d = HALTED;
            else                       pc_d    = pc_plus_4;
          end else begin
            fd_valid_d = 1'b0;
          end
        end
`ifdef FETCH_SKID_EN
        HOLD: begin
          fd_instr_d = skid_instr_q;
          fd_pc4_d   = skid_pc4_q;
          fd_valid_d = 1'b1;
          if (skid_instr_q == HALT_WORD) begin
            state_d = HALTED;
          end else begin
            pc_d    = pc_plus_4;
            state_d = FETCH;
          end
        end
`endif
        HALTED:  fd_valid_d = 1'b0;
        default: state_d = FETCH;
      endcase
    end
    ren_d    = (state_d == FETCH);
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= FETCH;
      pc_q       <= PC_INIT;
      fd_instr_q <= '0;
      fd_pc4_q   <= '0;
      fd_valid_q <= 1'b0;
      ren_q      <= 1'b1;
      halted_q   <= 1'b0;
`ifdef FETCH_SKID_EN
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fd_instr_q <= fd_instr_d;
      fd_pc4_q   <= fd_pc4_d;
      fd_valid_q <= fd_valid_d;
      ren_q      <= ren_d;
      halted_q   <= halted_d;
`ifdef FETCH_SKID_EN
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
`endif
    end
  end

  assign imemREN      = ren_q;
  assign imemaddr     = pc_q;
  assign fd_instr     = fd_instr_q;
  assign fd_pc_plus_4 = fd_pc4_q;
  assign fd_valid     = fd_valid_q;
  assign fetch_halted = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage; expected FD entries go through a scoreboard queue.
// Covers both builds (FETCH_SKID_EN defined or not).
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, stall, flush, redirect;
  logic [31:0] imemload, redirect_addr;
  logic        imemREN, fd_valid, fetch_halted;
  logic [31:0] imemaddr, fd_instr, fd_pc_plus_4;
  logic        w_imemREN, w_fd_valid, w_fetch_halted;
  logic [31:0] w_imemaddr, w_fd_instr, w_fd_pc_plus_4;

  typedef struct packed {logic [31:0] instr; logic [31:0] pc4;} fd_t;
  fd_t sb[$];
  fd_t e;
  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  fetch_stage dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_addr(redirect_addr), .imemREN(imemREN), .imemaddr(imemaddr),
    .fd_instr(fd_instr), .fd_pc_plus_4(fd_pc_plus_4), .fd_valid(fd_valid), .fetch_halted(fetch_halted)
  );

  fetch_stage #(.PC_INIT(32'hFFFFFFFC)) dut_w (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_addr(redirect_addr), .imemREN(w_imemREN), .imemaddr(w_imemaddr),
    .fd_instr(w_fd_instr), .fd_pc_plus_4(w_fd_pc_plus_4), .fd_valid(w_fd_valid), .fetch_halted(w_fetch_halted)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0:   mem = 32'h20080001;
      32'h4:   mem = 32'h20090002;
      default: mem = {8'h24, a[23:0]};
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ihit = 0; stall = 0; flush = 0; redirect = 0; imemload = '0; redirect_addr = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    nRST = 0;
    repeat (2) @(posedge CLK);
    #1;
    sb.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (imemREN !== 1'b1) begin failures++; $display("FAIL rst_ren got=%b exp=1", imemREN); end
    checks++; if (imemaddr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", imemaddr); end
    checks++; if (fetch_halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%b exp=0", fetch_halted); end
    checks++; if (fd_valid !== 1'b0 || fd_instr !== 32'h0 || fd_pc_plus_4 !== 32'h0) begin failures++;
      $display("FAIL rst_fd got=%b/%h/%h exp=0/0/0", fd_valid, fd_instr, fd_pc_plus_4); end
    checks++; if (w_imemaddr !== 32'hFFFFFFFC) begin failures++; $display("FAIL rst_init got=%h exp=fffffffc", w_imemaddr); end
    nRST = 1;
  endtask

  // Straight-line fetch of 0 and 4 with ihit every cycle.
  task automatic test_fetch_seq();
    logic [31:0] pc = 32'h0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (imemaddr !== pc) begin failures++; $display("FAIL seq_addr%0d got=%h exp=%h", i, imemaddr, pc); end
      ihit = 1; imemload = mem(pc);
      sb.push_back('{instr: mem(pc), pc4: pc + 32'd4});
      tick();
      pc = pc + 32'd4;
      e = sb.pop_front();
      checks++; if (fd_valid !== 1'b1 || fd_instr !== e.instr || fd_pc_plus_4 !== e.pc4) begin failures++;
        $display("FAIL seq_fd%0d got=%b/%h/%h exp=1/%h/%h", i, fd_valid, fd_instr, fd_pc_plus_4, e.instr, e.pc4); end
    end
    checks++; if (imemaddr !== 32'h8) begin failures++; $display("FAIL seq_addr2 got=%h exp=8", imemaddr); end
  endtask

  // Two-cycle stall with a hit at PC 8.
  task automatic test_stall();
    stall = 1; ihit = 1; imemload = mem(32'h8);
    sb.push_back('{instr: mem(32'h8), pc4: 32'hC});
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (fd_valid !== 1'b1 || fd_pc_plus_4 !== 32'h8 || fd_instr !== mem(32'h4)) begin failures++;
        $display("FAIL stall_hold%0d got=%b/%h/%h exp=1/%h/8", i, fd_valid, fd_instr, fd_pc_plus_4, mem(32'h4)); end
      checks++; if (imemaddr !== 32'h8) begin failures++; $display("FAIL stall_addr%0d got=%h exp=8", i, imemaddr); end
`ifdef FETCH_SKID_EN
      checks++; if (imemREN !== 1'b0) begin failures++; $display("FAIL stall_ren%0d got=%b exp=0", i, imemREN); end
      ihit = 0;
`else
      checks++; if (imemREN !== 1'b1) begin failures++; $display("FAIL stall_ren%0d got=%b exp=1", i, imemREN); end
`endif
    end
    stall = 0;
`ifndef FETCH_SKID_EN
    ihit = 1; imemload = mem(32'h8);
`endif
    tick();
    e = sb.pop_front();
    checks++; if (fd_valid !== 1'b1 || fd_instr !== e.instr || fd_pc_plus_4 !== e.pc4) begin failures++;
      $display("FAIL stall_release got=%b/%h/%h exp=1/%h/%h", fd_valid, fd_instr, fd_pc_plus_4, e.instr, e.pc4); end
    checks++; if (imemaddr !== 32'hC || imemREN !== 1'b1) begin failures++;
      $display("FAIL stall_next got=%h/%b exp=c/1", imemaddr, imemREN); end
  endtask

  task automatic test_bubble();
    ihit = 0;
    tick();
    checks++; if (fd_valid !== 1'b0 || imemaddr !== 32'hC || imemREN !== 1'b1) begin failures++;
      $display("FAIL bubble got=%b/%h/%b exp=0/c/1", fd_valid, imemaddr, imemREN); end
  endtask

  // Redirect wins over flush, stall and a same-cycle hit.
  task automatic test_redirect();
    redirect = 1; redirect_addr = 32'h40; flush = 1; stall = 1; ihit = 1; imemload = 32'hDEADBEEF;
    tick();
    idle_inputs();
    checks++; if (imemaddr !== 32'h40 || fd_valid !== 1'b0 || fd_instr !== 32'h0) begin failures++;
      $display("FAIL redirect got=%h/%b/%h exp=40/0/0", imemaddr, fd_valid, fd_instr); end
    ihit = 1; imemload = mem(32'h40);
    sb.push_back('{instr: mem(32'h40), pc4: 32'h44});
    tick();
    ihit = 0;
    e = sb.pop_front();
    checks++; if (fd_valid !== 1'b1 || fd_instr !== e.instr || fd_pc_plus_4 !== e.pc4) begin failures++;
      $display("FAIL redirect_fetch got=%b/%h/%h exp=1/%h/%h", fd_valid, fd_instr, fd_pc_plus_4, e.instr, e.pc4); end
  endtask

  task automatic test_flush();
    flush = 1; ihit = 1; imemload = 32'h0BADF00D;
    tick();
    idle_inputs();
    checks++; if (fd_valid !== 1'b0 || fd_instr !== 32'h0 || imemaddr !== 32'h44 || imemREN !== 1'b1) begin failures++;
      $display("FAIL flush got=%b/%h/%h/%b exp=0/0/44/1", fd_valid, fd_instr, imemaddr, imemREN); end
  endtask

  task automatic test_halt();
    redirect = 1; redirect_addr = 32'h10;
    tick();
    idle_inputs();
    ihit = 1; imemload = 32'hFFFFFFFF;
    tick();
    ihit = 0;
    checks++; if (fd_instr !== 32'hFFFFFFFF || fd_pc_plus_4 !== 32'h14 || fd_valid !== 1'b1) begin failures++;
      $display("FAIL halt_fd got=%h/%h/%b exp=ffffffff/14/1", fd_instr, fd_pc_plus_4, fd_valid); end
    checks++; if (fetch_halted !== 1'b1 || imemREN !== 1'b0 || imemaddr !== 32'h10) begin failures++;
      $display("FAIL halt_state got=%b/%b/%h exp=1/0/10", fetch_halted, imemREN, imemaddr); end
    tick();
    checks++; if (fd_valid !== 1'b0 || fetch_halted !== 1'b1 || imemaddr !== 32'h10) begin failures++;
      $display("FAIL halt_idle got=%b/%b/%h exp=0/1/10", fd_valid, fetch_halted, imemaddr); end
    redirect = 1; redirect_addr = 32'h20;
    tick();
    idle_inputs();
    checks++; if (fetch_halted !== 1'b0 || imemREN !== 1'b1 || imemaddr !== 32'h20) begin failures++;
      $display("FAIL halt_exit got=%b/%b/%h exp=0/1/20", fetch_halted, imemREN, imemaddr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc = 32'h100;
    redirect = 1; redirect_addr = pc;
    tick();
    idle_inputs();
    for (int i = 0; i < 6; i++) begin
      ihit = 1; imemload = mem(pc);
      sb.push_back('{instr: mem(pc), pc4: pc + 32'd4});
      tick();
      pc = pc + 32'd4;
      e = sb.pop_front();
      checks++; if (fd_valid !== 1'b1 || fd_instr !== e.instr || fd_pc_plus_4 !== e.pc4 || imemaddr !== pc) begin failures++;
        $display("FAIL b2b%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", i, fd_valid, fd_instr, fd_pc_plus_4, imemaddr, e.instr, e.pc4, pc); end
    end
    ihit = 0;
  endtask

  task automatic test_wrap();
    apply_reset();
    nRST = 1;
    ihit = 1; imemload = 32'h12345678;
    tick();
    ihit = 0;
    checks++; if (w_fd_pc_plus_4 !== 32'h0 || w_imemaddr !== 32'h0 || w_fd_instr !== 32'h12345678) begin failures++;
      $display("FAIL wrap got=%h/%h/%h exp=0/0/12345678", w_fd_pc_plus_4, w_imemaddr, w_fd_instr); end
  endtask

  // Asynchronous reset while holding a captured word (HOLD) or halted (no skid).
  task automatic test_reset_mid();
    apply_reset();
    nRST = 1;
    ihit = 1; imemload = mem(32'h0);
    tick();
`ifdef FETCH_SKID_EN
    stall = 1; ihit = 1; imemload = mem(32'h4);
`else
    ihit = 1; imemload = 32'hFFFFFFFF;
`endif
    tick();
    idle_inputs();
    checks++; if (imemREN !== 1'b0 || fd_valid !== 1'b1) begin failures++;
      $display("FAIL mid_setup got=%b/%b exp=0/1", imemREN, fd_valid); end
    #2 nRST = 0;
    #1;
    checks++; if (fd_valid !== 1'b0 || imemaddr !== 32'h0 || imemREN !== 1'b1 || fetch_halted !== 1'b0) begin failures++;
      $display("FAIL mid_async got=%b/%h/%b/%b exp=0/0/1/0", fd_valid, imemaddr, imemREN, fetch_halted); end
    tick();
    nRST = 1;
    tick();
    checks++; if (fd_valid !== 1'b0 || imemaddr !== 32'h0 || imemREN !== 1'b1) begin failures++;
      $display("FAIL mid_after got=%b/%h/%b exp=0/0/1", fd_valid, imemaddr, imemREN); end
  endtask

  initial begin
    idle_inputs();
    nRST = 0;
    test_reset();
    test_fetch_seq();
    test_stall();
    test_bubble();
    test_redirect();
    test_flush();
    test_halt();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_INIT, default 32'h00000000: PC value loaded on reset.
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 nRST  in  1  asynchronous active-low reset.
REQ-004 ihit  in  1  instruction memory returned imemload for imemaddr this cycle.
REQ-005 imemload  in  32  instruction word from memory.
REQ-006 stall  in  1  hazard unit holds FD latch; no advance.
REQ-007 flush  in  1  squash FD latch contents to bubble.
REQ-008 redirect  in  1  branch/jump resolved taken; load redirect_addr.
REQ-009 redirect_addr  in  32  new PC, word aligned.
REQ-010 imemREN  out  1  instruction read request.
REQ-011 imemaddr  out  32  current PC.
REQ-012 fd_instr  out  32  FD latch instruction, feeds FD_in.instr.
REQ-013 fd_pc_plus_4  out  32  FD latch PC+4, feeds FD_in.pc_plus_4.
REQ-014 fd_valid  out  1  FD latch holds a real instruction.
REQ-015 fetch_halted  out  1  HALT fetched; fetch stopped.

Function
REQ-016 States SHALL be FETCH, HOLD, HALTED; imemREN SHALL be 1 only in FETCH; fetch_halted SHALL be 1 only in HALTED; imemaddr SHALL equal PC at all times.
REQ-017 Per-cycle priority SHALL be redirect > flush > stall > ihit.
REQ-018 Redirect (any state): PC <= redirect_addr, fd_valid <= 0, fd_instr <= 0, skid buffer discarded, next state FETCH; same-cycle ihit data discarded.
REQ-019 Flush without redirect: fd_valid <= 0, fd_instr <= 0; PC and state unchanged; same-cycle ihit data discarded and PC re-requested.
REQ-020 FETCH, ihit, no stall: fd_instr <= imemload, fd_pc_plus_4 <= PC+4, fd_valid <= 1, PC <= PC+4 (mod 2^32, 32'hFFFFFFFC wraps to 0); one-cycle latency ihit to FD output.
REQ-021 FETCH, ihit, imemload == 32'hFFFFFFFF (HALT), no stall: latch as REQ-020, PC not advanced, next state HALTED.
REQ-022 FETCH, no ihit, no stall: fd_valid <= 0 (bubble), PC held.
REQ-023 Stall (any state, no redirect/flush): fd_instr, fd_pc_plus_4, fd_valid held unchanged.
REQ-024 FETCH, ihit with stall: behaviour per REQ-032/033.
REQ-025 HOLD, stall deasserted: FD <= skid contents (fd_valid <= 1), PC <= PC+4, next state FETCH, or HALTED if skid holds HALT (PC not advanced).
REQ-026 HALTED: no requests; FD advances to bubble when not stalled; exit only via redirect or reset.
REQ-027 imemREN SHALL remain asserted and imemaddr stable in FETCH until ihit, redirect, or flush.

Reset
REQ-028 nRST low SHALL asynchronously force PC = PC_INIT, state FETCH, fd_instr = 0, fd_pc_plus_4 = 0, fd_valid = 0, skid empty.
REQ-029 Outputs during reset: imemREN = 1, imemaddr = PC_INIT, fetch_halted = 0.
REQ-030 Reset mid-HOLD or mid-HALTED SHALL discard all captured state; first request after release is PC_INIT.

Configuration
REQ-031 Macro FETCH_SKID_EN SHALL select a one-entry skid buffer (instr, pc_plus_4).
REQ-032 With FETCH_SKID_EN: FETCH, ihit with stall captures imemload into skid, PC held, next state HOLD.
REQ-033 Without FETCH_SKID_EN: FETCH, ihit with stall discards imemload, stays FETCH, re-requests same PC; HOLD state unreachable and not implemented.

Verification
REQ-034 Reset release, ihit every cycle, imem 0:20080001, 4:20090002 -> imemaddr 0,4,8; fd_instr 20080001 then 20090002, fd_pc_plus_4 4 then 8, fd_valid 1 from cycle 1.
REQ-035 stall high 2 cycles with ihit at PC 8 -> FD holds PC+4=8 entry; skid build: HOLD entered, imemREN 0, fd_pc_plus_4=12 one cycle after stall drops; non-skid build: PC 8 re-requested.
REQ-036 redirect=1, redirect_addr=0x40 with same-cycle flush, stall, ihit -> next cycle imemaddr 0x40, fd_valid 0, fetched word dropped.
REQ-037 HALT 0xFFFFFFFF at PC 0x10 -> fd_instr FFFFFFFF, fd_pc_plus_4 0x14, fetch_halted 1, imemREN 0, imemaddr stays 0x10; redirect to 0x20 -> FETCH, imemaddr 0x20.
REQ-038 PC_INIT=0xFFFFFFFC, ihit -> fd_pc_plus_4 0, next imemaddr 0.
REQ-039 nRST pulsed low while in HOLD -> asynchronously fd_valid 0, imemaddr PC_INIT, skid empty, imemREN 1.
